// File: rtl/demux_deser_if.sv
`default_nettype none
// ============================================================================
// Module  : demux_deser_if
// Purpose : Bundles the demux_deser input bit stream (en/sel/din) and the
//           word output port (dout/dout_ch/dout_valid/dout_ready/ovf).
// Ports   : master - the environment (drives bit stream and dout_ready)
//           slave  - the collector (drives the word, channel, valid and ovf)
// Rev     : 1.0  initial release
// ============================================================================
interface demux_deser_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       sel;
  logic [3:0]       din;
  logic [WIDTH-1:0] dout;
  logic [1:0]       dout_ch;
  logic             dout_valid;
  logic             dout_ready;
  logic [3:0]       ovf;

  modport master (
    output en, sel, din, dout_ready,
    input  dout, dout_ch, dout_valid, ovf
  );

  modport slave (
    input  en, sel, din, dout_ready,
    output dout, dout_ch, dout_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/demux_deser.sv
`default_nettype none
// ============================================================================
// Module  : demux_deser
// Purpose : Four-channel serial-to-parallel collector behind a 1-to-4 demux.
//           Each enabled cycle din[sel] is shifted into channel sel; every
//           WIDTH bits the word is parked in a per-channel holding register
//           and handed out through a round-robin valid/ready output stage.
// Ports   : clk        - clock, rising edge
//           rst_n      - synchronous active-low reset
//           bus.en/sel/din          - incoming bit stream
//           bus.dout/dout_ch/dout_valid/dout_ready - word output handshake
//           bus.ovf    - sticky per-channel overflow flags
// Config  : DEMUX_DESER_MSB_FIRST_EN defined -> first received bit lands in
//           dout[WIDTH-1]; undefined -> first received bit lands in dout[0].
// Rev     : 1.0  initial release
// ============================================================================
module demux_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_deser_if.slave  bus
);

  localparam int unsigned          c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);

  logic [WIDTH-1:0]   r_shift [4];
  logic [WIDTH-1:0]   r_hold  [4];
  logic [c_CNT_W-1:0] r_cnt   [4];
  logic [3:0]         r_hold_full;
  logic [3:0]         r_ovf;
  logic [WIDTH-1:0]   r_dout;
  logic [1:0]         r_dout_ch;
  logic               r_dout_valid;
  logic [1:0]         r_rr;

  logic               w_bit;
  logic [WIDTH-1:0]   w_next_word;
  logic               w_done;
  logic               w_grant_vld;
  logic [1:0]         w_grant_ch;
  logic               w_load;

  assign w_bit = bus.din[bus.sel];

  // Shift direction decides where the first bit of a word ends up once
  // WIDTH bits have passed through the register.
`ifdef DEMUX_DESER_MSB_FIRST_EN
  assign w_next_word = {r_shift[bus.sel][WIDTH-2:0], w_bit};
`else
  assign w_next_word = {w_bit, r_shift[bus.sel][WIDTH-1:1]};
`endif

  assign w_done = bus.en && (r_cnt[bus.sel] == c_LAST);

  // Round-robin search starting at r_rr; first full holding register wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!w_grant_vld && r_hold_full[r_rr + 2'(i)]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = r_rr + 2'(i);
      end
    end
  end

  // Output register accepts a new word when empty or being consumed.
  assign w_load = w_grant_vld && (!r_dout_valid || bus.dout_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 4; ch++) begin
        r_shift[ch] <= '0;
        r_hold[ch]  <= '0;
        r_cnt[ch]   <= '0;
      end
      r_hold_full  <= 4'b0000;
      r_ovf        <= 4'b0000;
      r_dout       <= '0;
      r_dout_ch    <= 2'd0;
      r_dout_valid <= 1'b0;
      r_rr         <= 2'd0;
    end else begin
      // Drain first; a same-edge completion below may set the flag again.
      if (w_load) begin
        r_hold_full[w_grant_ch] <= 1'b0;
      end

      if (bus.en) begin
        r_shift[bus.sel] <= w_next_word;
        if (w_done) begin
          r_cnt[bus.sel] <= '0;
          if (!r_hold_full[bus.sel] || (w_load && (w_grant_ch == bus.sel))) begin
            r_hold[bus.sel]      <= w_next_word;
            r_hold_full[bus.sel] <= 1'b1;
          end else begin
            r_ovf[bus.sel] <= 1'b1;
          end
        end else begin
          r_cnt[bus.sel] <= r_cnt[bus.sel] + c_ONE;
        end
      end

      if (w_load) begin
        r_dout       <= r_hold[w_grant_ch];
        r_dout_ch    <= w_grant_ch;
        r_dout_valid <= 1'b1;
        r_rr         <= w_grant_ch + 2'd1;
      end else if (r_dout_valid && bus.dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
  assign bus.dout_valid = r_dout_valid;
  assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire
